// File: rtl/pc_pkg.sv
// Shared types for the program counter: command encoding and the
// priority decode that turns the raw control strobes into one action.
package pc_pkg;

    typedef enum logic [2:0] {
        CMD_HOLD,
        CMD_INC,
        CMD_LOAD,
        CMD_CALL,
        CMD_RET
    } pc_cmd_e;

    // Exactly one action per cycle: load > call > ret > inc > hold.
    function automatic pc_cmd_e pc_decode(input logic load, input logic call,
                                          input logic ret, input logic inc);
        pc_cmd_e cmd;
        cmd = CMD_HOLD;
        if (load)      cmd = CMD_LOAD;
        else if (call) cmd = CMD_CALL;
        else if (ret)  cmd = CMD_RET;
        else if (inc)  cmd = CMD_INC;
        return cmd;
    endfunction

endpackage

// File: rtl/ras_lifo.sv
// Circular-buffer return-address stack. A push while full overwrites the
// oldest entry; a pop while empty changes nothing.
module ras_lifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
    output logic                       full,
    output logic                       push_over
);

    localparam int PW = $clog2(DEPTH);
    localparam int DW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    top;
    logic [PW-1:0]    top_up;
    logic [PW-1:0]    top_dn;
    logic [DW-1:0]    count;

    // Wrap against DEPTH so non-power-of-two sizes stay in range.
    assign top_up = (top == PW'(DEPTH-1)) ? '0 : top + 1'b1;
    assign top_dn = (top == '0) ? PW'(DEPTH-1) : top - 1'b1;

    assign rdata     = mem[top];
    assign depth     = count;
    assign empty     = (count == '0);
    assign full      = (count == DW'(DEPTH));
    assign push_over = push && full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            top   <= '0;
            count <= '0;
        end else if (push) begin
            top <= top_up;
            if (!full) count <= count + 1'b1;
        end else if (pop && !empty) begin
            top   <= top_dn;
            count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[top_up] <= wdata;
    end

endmodule

// File: rtl/pc_ras.sv
// Program counter with integrated return-address stack for call/return,
// plus sticky overflow/underflow flags. Output is fully registered.
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 8,
    parameter int STEP       = 1,
    parameter int RESET_ADDR = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in,
    input  logic                       inc,
    input  logic                       load,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       err_clr,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
    output logic                       full,
    output logic                       ovf,
    output logic                       udf
);

    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_ADDR);

    pc_cmd_e          cmd;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_plus;
    logic [WIDTH-1:0] top_addr;
    logic             push;
    logic             pop;
    logic             push_over;
    logic             pop_under;

    assign cmd       = pc_decode(load, call, ret, inc);
    assign pc_plus   = pc_q + STEP_W;
    assign push      = (cmd == CMD_CALL);
    assign pop       = (cmd == CMD_RET);
    assign pop_under = pop && empty;

    ras_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .wdata     (pc_plus),
        .rdata     (top_addr),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .push_over (push_over)
    );

    always_comb begin
        pc_d = pc_q;
        case (cmd)
            CMD_LOAD: pc_d = in;
            CMD_CALL: pc_d = in;
            CMD_RET:  if (!empty) pc_d = top_addr;
            CMD_INC:  pc_d = pc_plus;
            default:  pc_d = pc_q;
        endcase
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_W;
            ovf  <= 1'b0;
            udf  <= 1'b0;
        end else begin
            pc_q <= pc_d;
            ovf  <= push_over || (ovf && !err_clr);
            udf  <= pop_under || (udf && !err_clr);
        end
    end

    assign out = pc_q;

endmodule

// File: tb/tb_pc_ras.sv
// Scoreboard bench for pc_ras (DEPTH=4): a queue-based reference stack
// predicts out/depth/flags per cycle; predictions are popped after the edge.
module tb_pc_ras;

    localparam int W = 16;
    localparam int D = 4;

    logic         clk;
    logic         reset;
    logic [W-1:0] in;
    logic         inc, load, call, ret, err_clr;
    logic [W-1:0] out;
    logic [2:0]   depth;
    logic         empty, full, ovf, udf;

    pc_ras #(.WIDTH(W), .DEPTH(D), .STEP(1), .RESET_ADDR(0)) dut (
        .clk(clk), .reset(reset), .in(in), .inc(inc), .load(load),
        .call(call), .ret(ret), .err_clr(err_clr), .out(out),
        .depth(depth), .empty(empty), .full(full), .ovf(ovf), .udf(udf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] m_pc;
    logic [W-1:0] m_stk[$];
    logic         m_ovf, m_udf;
    logic [22:0]  exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = '0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic model_step(input logic l, input logic c, input logic r,
                              input logic i, input logic clr, input logic [W-1:0] d);
        logic so, su;
        so = 1'b0;
        su = 1'b0;
        if (l) begin
            m_pc = d;
        end else if (c) begin
            m_stk.push_back(m_pc + 16'd1);
            if (m_stk.size() > D) begin
                void'(m_stk.pop_front());
                so = 1'b1;
            end
            m_pc = d;
        end else if (r) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else su = 1'b1;
        end else if (i) begin
            m_pc = m_pc + 16'd1;
        end
        m_ovf = so | (m_ovf & ~clr);
        m_udf = su | (m_udf & ~clr);
    endtask

    function automatic logic [22:0] model_pack();
        return {m_pc, 3'(m_stk.size()), m_ovf, m_udf,
                (m_stk.size() == 0), (m_stk.size() == D)};
    endfunction

    task automatic compare_out();
        logic [22:0] e;
        if (exp_q.size() == 0) begin
            check("exp_q_underrun", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        check("out",   out,   e[22:7]);
        check("depth", depth, e[6:4]);
        check("ovf",   ovf,   e[3]);
        check("udf",   udf,   e[2]);
        check("empty", empty, e[1]);
        check("full",  full,  e[0]);
    endtask

    // driver: one command per cycle, driven at negedge, checked after posedge
    task automatic cycle(input logic l, input logic c, input logic r,
                         input logic i, input logic clr, input logic [W-1:0] d);
        @(negedge clk);
        load = l; call = c; ret = r; inc = i; err_clr = clr; in = d;
        model_step(l, c, r, i, clr, d);
        exp_q.push_back(model_pack());
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic idle_inputs();
        load = 0; call = 0; ret = 0; inc = 0; err_clr = 0; in = '0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", out, 0);
        check("rst_depth", depth, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_flags", {ovf, udf}, 0);
        @(negedge clk);
        reset = 1'b0;

        // inc x3, then asynchronous reset mid-sequence
        repeat (3) cycle(0, 0, 0, 1, 0, '0);
        check("inc3_out", out, 3);
        @(negedge clk);
        idle_inputs();
        #2 reset = 1'b1;
        #1;
        check("async_rst_out", out, 0);
        check("async_rst_depth", depth, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // call / return
        cycle(1, 0, 0, 0, 0, 16'h0010);
        cycle(0, 1, 0, 0, 0, 16'h0200);
        check("call_out", out, 16'h0200);
        check("call_depth", depth, 1);
        cycle(0, 0, 0, 1, 0, '0);
        cycle(0, 0, 0, 1, 0, '0);
        cycle(0, 0, 1, 0, 0, '0);
        check("ret_out", out, 16'h0011);
        check("ret_empty", empty, 1);

        // nested calls overflow the 4-deep stack
        cycle(1, 0, 0, 0, 0, 16'h0100);
        for (int k = 0; k < 5; k++) begin
            cycle(0, 1, 0, 0, 0, 16'h0101 + 16'(k));
            if (k == 3) check("full_after4", full, 1);
        end
        check("ovf_after5", ovf, 1);
        check("depth_full", depth, 4);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 1, 0, 0, '0);
            check("nested_ret", out, 16'h0105 - 16'(k));
        end
        check("nested_empty", empty, 1);
        cycle(0, 0, 0, 0, 1, '0);

        // underflow and sticky clear
        cycle(1, 0, 0, 0, 0, 16'h0042);
        cycle(0, 0, 1, 0, 0, '0);
        check("udf_out", out, 16'h0042);
        check("udf_set", udf, 1);
        cycle(0, 0, 0, 0, 1, '0);
        check("udf_clr", udf, 0);
        cycle(0, 0, 1, 0, 1, '0);
        check("udf_set_wins", udf, 1);
        cycle(0, 0, 0, 0, 1, '0);

        // wrap
        cycle(1, 0, 0, 0, 0, 16'hFFFF);
        cycle(0, 0, 0, 1, 0, '0);
        check("wrap_out", out, 0);
        cycle(1, 0, 0, 0, 0, 16'hFFFF);
        cycle(0, 1, 0, 0, 0, 16'h0300);
        cycle(0, 0, 1, 0, 0, '0);
        check("wrap_push", out, 0);

        // priority
        cycle(0, 1, 0, 0, 0, 16'h0400);
        cycle(1, 1, 1, 1, 0, 16'h1234);
        check("prio_load", out, 16'h1234);
        check("prio_depth", depth, 1);
        cycle(0, 1, 1, 0, 0, 16'h0500);
        check("call_ret_depth", depth, 2);
        check("call_ret_udf", udf, 0);

        // random traffic
        for (int n = 0; n < 200; n++) begin
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0,
                  $urandom_range(0, 9) == 0, W'($urandom));
        end
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_ras.md
Name: pc_ras

Overview:
- Parametrised program counter with an integrated return-address stack (RAS) for CPU call/return sequences.
- Successor to the fixed 16-bit counter: generic width, configurable increment step and reset vector, plus call/ret commands and overflow/underflow reporting.
- Sits in the CPU fetch path; `out` drives instruction-memory address.

Parameters:
- WIDTH, 16, counter and address width in bits.
- DEPTH, 8, return-address stack entries (>=2).
- STEP, 1, increment amount applied on inc and used to form the return address.
- RESET_ADDR, 0, counter value after reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in  input  WIDTH  jump/call target.
- inc  input  1  advance counter by STEP.
- load  input  1  jump: counter <= in.
- call  input  1  push return address, counter <= in.
- ret  input  1  pop: counter <= top of stack.
- err_clr  input  1  clears sticky error flags.
- out  output  WIDTH  current counter value (registered).
- depth  output  $clog2(DEPTH+1)  valid entries in stack.
- empty  output  1  depth == 0.
- full  output  1  depth == DEPTH.
- ovf  output  1  sticky: call issued while full.
- udf  output  1  sticky: ret issued while empty.

Behaviour:
- Reset (asynchronous, active-high, immediate): out=RESET_ADDR, depth=0, empty=1, full=0, ovf=0, udf=0. Stack contents are don't-care.
- Reset mid-operation discards any command in that cycle; the first command is accepted on the first rising edge with reset low.
- Command priority per cycle, one action only: load > call > ret > inc > hold.
- Latency: out reflects the selected command one cycle after the sampling edge. depth, empty and full update on the same edge.
- load: counter <= in. Stack unchanged.
- call: counter <= in.
  - Push (counter + STEP) mod 2^WIDTH.
  - If not full: depth+1.
  - If full: oldest entry overwritten (circular), depth stays DEPTH, ovf <= 1.
- ret (if not preceded by load/call):
  - If depth>0: counter <= top, depth-1.
  - If empty: counter holds, depth stays 0, udf <= 1.
- inc: counter <= (counter + STEP) mod 2^WIDTH. Wraps silently; no flag.
- Simultaneous call+ret: call wins; ret ignored with no flag.
- Simultaneous load+anything: load wins; stack untouched.
- err_clr: clears ovf/udf on the next edge. If a new error occurs in the same cycle, the set wins.
- The stack is implemented as a circular buffer with a top pointer of $clog2(DEPTH) bits. Pointer wrap uses DEPTH (non-power-of-two DEPTH supported).
- No combinational path from inputs to out.

Decomposition:
- Package pc_pkg:
  - enum pc_cmd_e {CMD_HOLD, CMD_INC, CMD_LOAD, CMD_CALL, CMD_RET}.
  - Priority-decode function (load, call, ret, inc) -> pc_cmd_e.
- Sub-module ras_lifo:
  - Parameters WIDTH and DEPTH; inputs push, pop, wdata.
  - Outputs rdata (top), depth, empty, full, push_over.
  - Implements overwrite-on-full; pop on empty is a no-op.
- pc_ras holds the counter register, command decode, STEP adder and sticky flags.

Test Plan:
- Reset then inc x3 (WIDTH=16, STEP=1, RESET_ADDR=0) -> out 0,1,2,3. Assert reset mid-sequence -> out=0 immediately, before the next edge.
- At out=0x0010, call in=0x0200 -> out=0x0200, depth=1. Then inc x2, then ret -> out=0x0011, depth=0, empty=1.
- DEPTH=4: nested calls from out=0x0100,0x0101,... 5 times -> full=1 after 4th, ovf=1 after 5th, depth=4. Then 4 rets -> the first return address is lost (most recent 4 returned); empty=1.
- ret while empty at out=0x0042 -> out stays 0x0042, udf=1. err_clr -> udf=0 next cycle.
- out=0xFFFF, inc -> out=0x0000, no flag. Call at out=0xFFFF -> pushed 0x0000.
- Same cycle load=1,call=1,ret=1,in=0x1234 -> out=0x1234, depth unchanged. call=1,ret=1 -> push occurs, no pop, udf unaffected.
